// File: rtl/imem_boot_controller_pkg.sv
// imem_boot_controller_pkg: state encoding and default geometry shared by the
// boot controller, the CPU and the instruction memory.
package imem_boot_controller_pkg;
   localparam int          IMEM_ADDR_W    = 8;
   localparam int          IMEM_DATA_W    = 16;
   localparam logic [15:0] IMEM_FILL_WORD = 16'h0000;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } state_e;
endpackage

// File: rtl/imem_boot_controller.sv
// imem_boot_controller: streams a program image into instruction memory, fills the rest,
// then hands the memory read port to CPU fetch; supports debug halt and reload.
module imem_boot_controller
   import imem_boot_controller_pkg::*;
#(
   parameter int                ADDR_W    = IMEM_ADDR_W,
   parameter int                DATA_W    = IMEM_DATA_W,
   parameter logic [DATA_W-1:0] FILL_WORD = IMEM_FILL_WORD
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_stall,
   input  logic              dbg_halt_req,
   input  logic              dbg_reload,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W:0]   load_count,
   output logic              busy
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              writing;
   logic              at_end;

   assign writing = (state_q == LOAD) || (state_q == CLEAR);
   assign at_end  = &wr_ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= LOAD;
         wr_ptr_q     <= '0;
         load_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         load_count_q <= load_count_d;
      end
   end

   // The last address always ends the image, whether or not ld_last is set on it.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      load_count_d = load_count_q;
      case (state_q)
         LOAD:
            if (ld_valid) begin
               wr_ptr_d     = wr_ptr_q + 1'b1;
               load_count_d = load_count_q + 1'b1;
               state_d      = at_end ? RUN : (ld_last ? CLEAR : LOAD);
            end
         CLEAR: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = at_end ? RUN : CLEAR;
         end
         RUN:
            state_d = dbg_halt_req ? HALT : RUN;
         HALT:
            if (dbg_reload) begin
               state_d      = LOAD;
               wr_ptr_d     = '0;
               load_count_d = '0;
            end else if (!dbg_halt_req) begin
               state_d = RUN;
            end
         default: state_d = LOAD;
      endcase
   end

   assign ld_ready   = state_q == LOAD;
   assign busy       = writing;
   assign cpu_stall  = state_q != RUN;
   assign mem_addr   = writing ? wr_ptr_q : cpu_pc;
   assign mem_wdata  = (state_q == LOAD) ? ld_data : FILL_WORD;
   assign mem_we     = (ld_valid && state_q == LOAD) || state_q == CLEAR;
   assign cpu_instr  = (state_q == RUN) ? mem_rdata : FILL_WORD;
   assign load_count = load_count_q;
endmodule

// File: tb/tb_imem_boot_controller.sv
// tb_imem_boot_controller: directed checks of load, clear, backpressure, overflow,
// debug halt/reload and mid-clear reset against a behavioural instruction memory.
module tb_imem_boot_controller;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        ld_valid, ld_ready, ld_last;
   logic [15:0] ld_data;
   logic [7:0]  cpu_pc;
   logic [15:0] cpu_instr;
   logic        cpu_stall, dbg_halt_req, dbg_reload;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_we;
   logic [8:0]  load_count;
   logic        busy;

   logic [15:0] mem [256];
   logic [23:0] wlog [$];
   int          n_chk = 0;
   int          n_pass = 0;

   imem_boot_controller dut (
      .clk(clk), .reset_n(reset_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
      .dbg_halt_req(dbg_halt_req), .dbg_reload(dbg_reload),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .load_count(load_count), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wlog.push_back({mem_addr, mem_wdata});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (cpu_stall && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic reload;
      dbg_halt_req = 1'b1;
      tick();
      dbg_reload = 1'b1;
      tick();
      dbg_halt_req = 1'b0;
      dbg_reload = 1'b0;
   endtask

   logic [15:0] prog [9] = '{16'h4000, 16'h4101, 16'h4202, 16'h8008, 16'h0123,
                             16'h1234, 16'h2345, 16'h3456, 16'hC3C8};
   logic [15:0] bp [4] = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333};

   initial begin
      int n, bad;
      reset_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
      cpu_pc = '0; dbg_halt_req = 1'b0; dbg_reload = 1'b0;
      #1;
      chk("rst_ready", ld_ready, 1);
      chk("rst_stall", cpu_stall, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 1);
      chk("rst_instr", cpu_instr, 16'h0000);
      chk("rst_count", load_count, 0);
      #11 reset_n = 1'b1;

      // nine-word program, ld_valid continuous
      ld_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ld_data = prog[i];
         ld_last = (i == 8);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("ld9_clear_busy", busy, 1);
      chk("ld9_clear_ready", ld_ready, 0);
      chk("ld9_clear_addr", mem_addr, 9);
      wait_run(n);
      chk("ld9_clear_cycles", n, 247);
      chk("ld9_wlog_size", wlog.size(), 256);
      bad = 0;
      for (int i = 0; i < 256 && i < wlog.size(); i++)
         if (wlog[i] !== {8'(i), (i < 9) ? prog[i] : 16'h0000}) bad++;
      chk("ld9_wlog_bad", bad, 0);
      chk("ld9_count", load_count, 9);
      chk("ld9_busy", busy, 0);
      cpu_pc = 8'd3;
      #1 chk("ld9_fetch3", cpu_instr, 16'b1000000000001000);
      cpu_pc = 8'd9;
      #1 chk("ld9_fetch9", cpu_instr, 16'h0000);

      // reload ignored in RUN
      dbg_reload = 1'b1;
      tick();
      dbg_reload = 1'b0;
      chk("run_reload_stall", cpu_stall, 0);
      chk("run_reload_count", load_count, 9);

      // halt, release, halt then reload with release
      cpu_pc = 8'd3;
      dbg_halt_req = 1'b1;
      #1 chk("halt_same_cycle", cpu_instr, 16'h8008);
      tick();
      chk("halt_stall", cpu_stall, 1);
      chk("halt_instr", cpu_instr, 16'h0000);
      chk("halt_we", mem_we, 0);
      chk("halt_addr", mem_addr, 3);
      dbg_halt_req = 1'b0;
      tick();
      chk("release_stall", cpu_stall, 0);
      chk("release_instr", cpu_instr, 16'h8008);
      dbg_halt_req = 1'b1;
      tick();
      dbg_halt_req = 1'b0;
      dbg_reload = 1'b1;
      tick();
      dbg_reload = 1'b0;
      chk("reload_ready", ld_ready, 1);
      chk("reload_count", load_count, 0);
      chk("reload_stall", cpu_stall, 1);

      // loader backpressure: valid on even cycles only
      wlog.delete();
      for (int k = 0; k < 7; k++) begin
         ld_valid = (k % 2 == 0);
         ld_data  = bp[k / 2];
         ld_last  = (k == 6);
         #1 chk("bp_we", mem_we, ld_valid);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("bp_count", load_count, 4);
      wait_run(n);
      chk("bp_clear_cycles", n, 252);
      bad = 0;
      for (int i = 0; i < 4 && i < wlog.size(); i++)
         if (wlog[i] !== {8'(i), bp[i]}) bad++;
      chk("bp_wlog_bad", bad, 0);
      chk("bp_wlog_size", wlog.size(), 256);
      cpu_pc = 8'd2;
      #1 chk("bp_fetch2", cpu_instr, 16'h2222);
      cpu_pc = 8'd8;
      #1 chk("bp_fetch8_cleared", cpu_instr, 16'h0000);

      // overflow: 256 words, ld_last never set
      reload();
      wlog.delete();
      ld_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ld_data = 16'(i) ^ 16'hA5A5;
         tick();
      end
      ld_valid = 1'b0;
      chk("ovf_stall", cpu_stall, 0);
      chk("ovf_count", load_count, 256);
      chk("ovf_wlog_size", wlog.size(), 256);
      cpu_pc = 8'd255;
      #1 chk("ovf_fetch255", cpu_instr, 16'hA55A);

      // reset in CLEAR at wr_ptr 100
      reload();
      ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h7777;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      for (int i = 0; i < 99; i++) tick();
      chk("clr_addr100", mem_addr, 100);
      chk("clr_we", mem_we, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_ready", ld_ready, 1);
      chk("midrst_we", mem_we, 0);
      chk("midrst_stall", cpu_stall, 1);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_count", load_count, 0);
      #2 reset_n = 1'b1;

      // reload ignored in LOAD
      dbg_reload = 1'b1;
      tick();
      dbg_reload = 1'b0;
      chk("load_reload_ready", ld_ready, 1);
      chk("load_reload_addr", mem_addr, 0);

      // two-word load then clear from address 2
      wlog.delete();
      ld_valid = 1'b1;
      ld_data = 16'hAAAA; ld_last = 1'b0;
      tick();
      ld_data = 16'hBBBB; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      chk("ld2_wlog0", wlog.size() > 0 ? wlog[0] : 24'hFFFFFF, {8'd0, 16'hAAAA});
      chk("ld2_wlog1", wlog.size() > 1 ? wlog[1] : 24'hFFFFFF, {8'd1, 16'hBBBB});
      chk("ld2_wlog2", wlog.size() > 2 ? wlog[2] : 24'hFFFFFF, {8'd2, 16'h0000});
      wait_run(n);
      chk("ld2_clear_cycles", n, 253);
      chk("ld2_count", load_count, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
Sequences the 256 x 16-bit instruction memory of the single-cycle CPU.
- After reset, streams a program from a loader interface into memory and fills unused locations with a fill word.
- Holds the CPU in stall until the image is complete, then hands the memory port to CPU fetch.
- Supports debug halt and reload.
- Sits between the CPU PC/instruction path, the loader source and a writable instruction memory with asynchronous read.

Parameters:
ADDR_W, 8, instruction address width; DEPTH = 2**ADDR_W
DATA_W, 16, instruction word width
FILL_WORD, 16'h0000, value written to unloaded locations and driven on cpu_instr while stalled

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts loader word
ld_data  in  DATA_W  instruction word from loader
ld_last  in  1  marks final word of image (qualified by ld_valid)
cpu_pc  in  ADDR_W  CPU fetch address
cpu_instr  out  DATA_W  instruction to CPU
cpu_stall  out  1  CPU must hold PC and state
dbg_halt_req  in  1  level; request halt from RUN
dbg_reload  in  1  single-cycle pulse; restart load from HALT
mem_addr  out  ADDR_W  instruction memory address
mem_wdata  out  DATA_W  instruction memory write data
mem_we  out  1  instruction memory write enable (written on rising clk)
mem_rdata  in  DATA_W  instruction memory asynchronous read data
load_count  out  ADDR_W+1  words accepted from loader in last/current load
busy  out  1  high in LOAD or CLEAR

Behaviour:
- State register: LOAD, CLEAR, RUN, HALT. Registers: state, wr_ptr[ADDR_W-1:0], load_count.
- Reset (async, reset_n=0):
  - state=LOAD, wr_ptr=0, load_count=0.
  - Outputs: ld_ready=1, cpu_stall=1, mem_we=0 (until handshake), busy=1, cpu_instr=FILL_WORD.
  - Memory contents are not touched.
- Outputs are combinational from state:
  - cpu_stall = (state != RUN).
  - busy = (state == LOAD or CLEAR).
  - ld_ready = (state == LOAD).
- LOAD:
  - mem_addr=wr_ptr, mem_wdata=ld_data, mem_we = ld_valid & ld_ready.
  - On accept: wr_ptr++, load_count++.
  - Accept with ld_last=1 and wr_ptr<DEPTH-1: go to CLEAR, wr_ptr = wr_ptr+1.
  - Accept with wr_ptr==DEPTH-1 (ld_last ignored): go to RUN; load_count=DEPTH; wr_ptr wraps to 0.
  - No accept: hold.
- CLEAR:
  - mem_addr=wr_ptr, mem_wdata=FILL_WORD, mem_we=1, one location per cycle.
  - At wr_ptr==DEPTH-1: go to RUN, wr_ptr=0. Otherwise wr_ptr++.
- RUN:
  - mem_addr=cpu_pc, mem_we=0, cpu_instr=mem_rdata (zero-cycle combinational path for single-cycle fetch).
  - dbg_halt_req=1 sampled: go to HALT next cycle. The instruction in that cycle still completes.
- HALT:
  - mem_addr=cpu_pc, mem_we=0, cpu_instr=FILL_WORD, stall=1.
  - dbg_reload=1: go to LOAD, wr_ptr=0, load_count=0. Has priority over halt release.
  - Otherwise dbg_halt_req=0: go to RUN.
- Outside HALT, dbg_reload is ignored. Outside RUN, dbg_halt_req is ignored except as the HALT release condition.
- mem_we is never asserted in RUN or HALT. Only one writer exists per cycle, so no write/fetch conflict.
- Reset mid-LOAD or mid-CLEAR aborts the load: return to LOAD at address 0; partial image remains in memory.
- load_count saturates naturally at DEPTH. Max value 256 requires ADDR_W+1 bits.

Decomposition:
- Shared package holds:
  - state encoding constants: LOAD=2'd0, CLEAR=2'd1, RUN=2'd2, HALT=2'd3
  - ADDR_W/DATA_W defaults
  - FILL_WORD default, shared with CPU and memory blocks
- Single module. The memory stays in its existing block, instantiated alongside by the top level with its write port added.
- No sub-module needed; the write-pointer counter is inline.

Test Plan:
- Load 9 words (li r0,0 … sm r3,200), ld_last on 9th, ld_valid continuous:
  - mem_we high for 9 cycles, then CLEAR writes addresses 9..255 with FILL_WORD over 247 cycles.
  - load_count=9; cpu_stall falls the cycle after address 255 is written.
  - With cpu_pc=3, cpu_instr=16'b1000000000001000.
- Loader backpressure: ld_valid toggled 1/0 every cycle for 4 words, last on 4th:
  - only valid cycles write (addresses 0..3 exactly, in order); wr_ptr holds during gaps.
- Overflow: 256 words, ld_last never asserted:
  - no CLEAR; RUN the cycle after word 255; load_count=256; word 255 readable at cpu_pc=255.
- Halt/reload from RUN:
  - dbg_halt_req=1 → stall=1 next cycle, cpu_instr=FILL_WORD.
  - Release → RUN.
  - Halt again, pulse dbg_reload together with dbg_halt_req=0 → LOAD (reload wins), load_count=0, ld_ready=1.
- Reset asserted in CLEAR at wr_ptr=100:
  - immediately state=LOAD, ld_ready=1, mem_we=0, cpu_stall=1.
  - New 2-word load then clears from address 2.
- dbg_reload pulsed in RUN and in LOAD: no effect; state and wr_ptr unchanged.
